light_input_conditioner: RTL and testbench
==========================================

# light_input_conditioner

Front-end stage that sits directly upstream of the lamp-control FSM and produces its `onClick`, `offClick` and `keypad` inputs. It synchronizes and debounces the raw on/off push-buttons and turns each debounced press into a single-cycle click pulse. It also runs a 4-digit access-code FSM on the keypad digit stream. `keypad` is held high while a correct code has been entered and the unlock window has not expired.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles needed to accept a button level change (range 1..255).
- `CODE`, default 16'h1234: access code, four BCD digits, most significant digit entered first.
- `UNLOCK_CYCLES`, default 1000: length of the unlock window in cycles (range 1..2^16-1).
- `LOCKOUT_CYCLES`, default 4000: length of the lockout after repeated failures (range 1..2^16-1).
- `MAX_FAILS`, default 3: number of consecutive failed entries that triggers lockout (range 1..7).
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `on_btn_raw`  in  1  asynchronous "on" push-button, active-high.
- `off_btn_raw`  in  1  asynchronous "off" push-button, active-high.
- `key_strobe`  in  1  one-cycle, clk-synchronous strobe marking a valid `key_digit`.
- `key_digit`  in  4  key code: 0–9 are digits, 4'hA is clear (`*`), 4'hB is enter (`#`), 4'hC–4'hF are ignored.
- `onClick`  out  1  one-cycle pulse per debounced "on" press.
- `offClick`  out  1  one-cycle pulse per debounced "off" press.
- `keypad`  out  1  level; high while the block is unlocked.
- `code_error`  out  1  one-cycle pulse on a rejected code entry.
- `locked_out`  out  1  level; high during lockout.

## Operation
- **Button path.** Each button passes through its own 2-flop synchronizer, then a debouncer.
  - The debouncer keeps a stable level and an 8-bit counter.
  - When the synchronized input differs from the stable level, the counter increments. When it matches, the counter clears.
  - When the counter reaches `DEBOUNCE_CYCLES`, the stable level toggles and the counter clears.
- **Click pulses.** A stable 0→1 transition produces a one-cycle registered pulse on `onClick` or `offClick`. A 1→0 transition produces nothing.
- **Simultaneous presses.** If both stable levels rise in the same cycle, neither pulse is issued.
- **Code FSM states.** IDLE, ENTRY, UNLOCKED, LOCKOUT.
- **IDLE.**
  - A digit strobe loads the digit into a 16-bit shift register, sets the digit count to 1 and moves to ENTRY.
  - Clear and enter strobes are ignored.
- **ENTRY.**
  - A digit strobe with count < 4: shift the digit in and increment the count.
  - A digit strobe with count = 4: set the overflow flag; the shift register is unchanged.
  - Clear: go to IDLE and reset the count, shift register and overflow flag. The fail counter is unchanged.
  - Enter with count = 4, overflow clear and register = `CODE`: go to UNLOCKED, clear the fail counter and load the unlock timer with `UNLOCK_CYCLES`.
  - Any other enter: pulse `code_error`, increment the fail counter and go to IDLE. If the new fail count equals `MAX_FAILS`, go to LOCKOUT instead and load the lockout timer with `LOCKOUT_CYCLES`.
- **UNLOCKED.**
  - `keypad` is 1.
  - The timer decrements every cycle. When it reaches 0, go to IDLE.
  - Each issued `onClick` or `offClick` reloads the timer with `UNLOCK_CYCLES`.
  - A clear strobe relocks immediately and goes to IDLE.
  - Digit and enter strobes are ignored.
- **LOCKOUT.**
  - `locked_out` is 1 and all strobes are ignored.
  - The timer decrements every cycle. When it reaches 0, clear the fail counter and go to IDLE.
- **Code FSM outputs.** `keypad` and `locked_out` are registered decodes of the state.
- **Key codes 4'hC–4'hF.** These are ignored in every state.
- **Debouncing is continuous.** Clicks are produced in every FSM state; the downstream block gates them with `keypad`.

## Timing
- **Reset values.**
  - All outputs are 0.
  - The FSM is in IDLE; counters, timers, shift register and overflow flag are 0.
  - Synchronizer and stable levels are 0.
  - Reset applies on the first rising edge where `reset` = 1 and overrides everything, including mid-entry and mid-lockout. A button that is already held at reset release produces a click after debounce.
- **Button latency.**
  - A raw 0→1 held steady is sampled into sync stage 1 at edge 0.
  - `onClick` (and likewise `offClick`) is high for exactly one cycle, in the cycle after edge `DEBOUNCE_CYCLES`+2.
  - Glitches shorter than `DEBOUNCE_CYCLES` cycles after synchronization produce no pulse.
- **Key latency.**
  - `keypad` rises in the cycle after the clk edge that samples the accepted enter strobe.
  - `code_error` pulses in that same cycle position for a rejected enter.
- **Unlock window.** With no refresh, `keypad` stays high for exactly `UNLOCK_CYCLES` cycles.
  - A refresh and expiry in the same cycle: the refresh wins.
  - A clear and a refresh in the same cycle: the clear wins.
- **Lockout window.** `locked_out` stays high for exactly `LOCKOUT_CYCLES` cycles.
- **Strobe rate.** `key_strobe` may be asserted on consecutive cycles; every strobe is processed.

## Test plan
- Raw `on_btn_raw` high for 40 cycles (default parameters) → exactly one `onClick` pulse, 19 cycles after the first sampling edge; `offClick` stays 0.
- `on_btn_raw` toggling every 5 cycles for 100 cycles → no `onClick`.
- Keys 1, 2, 3, 4, # → `keypad` = 1 for 1000 cycles, then 0.
  - Same run with an `offClick` at cycle 500 → `keypad` falls 1000 cycles after that click.
- Keys 1, 2, 3, 5, # → `code_error` pulse, `keypad` stays 0.
- Keys 1, 2, 3, 4, 4, # (overflow) → `code_error` pulse, `keypad` stays 0.
- Three bad entries → `locked_out` high for 4000 cycles, during which 1, 2, 3, 4, # is ignored; afterwards a correct entry unlocks.
  - Reset asserted mid-lockout → all outputs 0 on the next edge.
- Both raw buttons rise on the same cycle → no clicks.
  - `*` while unlocked → `keypad` drops the next cycle.

Source files
------------

// File: rtl/light_input_conditioner_if.sv
// light_input_conditioner_if: raw buttons and keypad strobes in, clicks and lock status out
interface light_input_conditioner_if;
    logic       on_btn_raw;
    logic       off_btn_raw;
    logic       key_strobe;
    logic [3:0] key_digit;
    logic       onClick;
    logic       offClick;
    logic       keypad;
    logic       code_error;
    logic       locked_out;
    modport master (
        output on_btn_raw, off_btn_raw, key_strobe, key_digit,
        input  onClick, offClick, keypad, code_error, locked_out
    );
    modport slave (
        input  on_btn_raw, off_btn_raw, key_strobe, key_digit,
        output onClick, offClick, keypad, code_error, locked_out
    );
endinterface

// File: rtl/light_input_conditioner.sv
// light_input_conditioner: debounced click pulses plus access-code unlock/lockout FSM
module light_input_conditioner #(
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [15:0] CODE            = 16'h1234,
    parameter int          UNLOCK_CYCLES   = 1000,
    parameter int          LOCKOUT_CYCLES  = 4000,
    parameter int          MAX_FAILS       = 3
) (
    input logic                      clk,
    input logic                      reset,
    light_input_conditioner_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ENTRY, UNLOCKED, LOCKOUT} state_t;
    state_t          state_q, state_d;
    logic [1:0]      sync1_q, sync2_q, stable_q, stable_prev_q, click_q, rise, click_d;
    logic [1:0][7:0] cnt_q;
    logic [15:0]     sr_q, sr_d, timer_q, timer_d;
    logic [2:0]      dcnt_q, dcnt_d, fails_q, fails_d;
    logic            ovf_q, ovf_d, err_q, err_d;
    logic            is_digit, is_clear, is_enter, refresh;

    assign rise     = stable_q & ~stable_prev_q;
    assign click_d  = (&rise) ? 2'b00 : rise;
    assign refresh  = |click_d;
    assign is_digit = bus.key_strobe && bus.key_digit <= 4'd9;
    assign is_clear = bus.key_strobe && bus.key_digit == 4'hA;
    assign is_enter = bus.key_strobe && bus.key_digit == 4'hB;

    // synchronize, debounce and edge-detect both buttons (bit 0 = on, bit 1 = off)
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            click_q       <= '0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= {bus.off_btn_raw, bus.on_btn_raw};
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            click_q       <= click_d;
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] == stable_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_q[b] == 8'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_q[b]    <= '0;
                    stable_q[b] <= ~stable_q[b];
                end else begin
                    cnt_q[b] <= cnt_q[b] + 8'd1;
                end
            end
        end
    end

    // code FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            timer_q <= '0;
            dcnt_q  <= '0;
            fails_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            timer_q <= timer_d;
            dcnt_q  <= dcnt_d;
            fails_q <= fails_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    // next state: digit collection, code check, unlock refresh and timer expiry
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        timer_d = timer_q;
        dcnt_d  = dcnt_q;
        fails_d = fails_q;
        ovf_d   = ovf_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_digit) begin
                    sr_d    = {12'd0, bus.key_digit};
                    dcnt_d  = 3'd1;
                    ovf_d   = 1'b0;
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (is_digit) begin
                    ovf_d  = ovf_q | (dcnt_q == 3'd4);
                    sr_d   = (dcnt_q == 3'd4) ? sr_q : {sr_q[11:0], bus.key_digit};
                    dcnt_d = (dcnt_q == 3'd4) ? dcnt_q : dcnt_q + 3'd1;
                end else if (is_clear) begin
                    state_d = IDLE;
                    sr_d    = '0;
                    dcnt_d  = '0;
                    ovf_d   = 1'b0;
                end else if (is_enter) begin
                    if (dcnt_q == 3'd4 && !ovf_q && sr_q == CODE) begin
                        state_d = UNLOCKED;
                        fails_d = '0;
                        timer_d = 16'(UNLOCK_CYCLES);
                    end else begin
                        err_d   = 1'b1;
                        fails_d = fails_q + 3'd1;
                        state_d = (fails_d == 3'(MAX_FAILS)) ? LOCKOUT : IDLE;
                        timer_d = (fails_d == 3'(MAX_FAILS)) ? 16'(LOCKOUT_CYCLES) : timer_q;
                    end
                end
            end
            UNLOCKED: begin
                if (is_clear) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (refresh) begin
                    timer_d = 16'(UNLOCK_CYCLES);
                end else begin
                    timer_d = timer_q - 16'd1;
                    state_d = (timer_q == 16'd1) ? IDLE : UNLOCKED;
                end
            end
            LOCKOUT: begin
                timer_d = timer_q - 16'd1;
                state_d = (timer_q == 16'd1) ? IDLE : LOCKOUT;
                fails_d = (timer_q == 16'd1) ? 3'd0 : fails_q;
            end
        endcase
    end

    // outputs: decode of the registered state and registered pulses
    always_comb begin
        bus.keypad     = state_q == UNLOCKED;
        bus.locked_out = state_q == LOCKOUT;
        bus.code_error = err_q;
        bus.onClick    = click_q[0];
        bus.offClick   = click_q[1];
    end
endmodule

// File: tb/tb_light_input_conditioner.sv
// tb_light_input_conditioner: directed and random stimulus against an event-level reference model
module tb_light_input_conditioner;
    localparam int          DEB    = 16;
    localparam logic [15:0] CODE_V = 16'h1234;
    localparam int          UNL    = 1000;
    localparam int          LCK    = 4000;
    localparam int          MF     = 3;
    localparam int          M_IDLE = 0, M_ENTRY = 1, M_UNLOCKED = 2, M_LOCKOUT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    light_input_conditioner_if bus ();

    light_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CODE(CODE_V),
        .UNLOCK_CYCLES(UNL),
        .LOCKOUT_CYCLES(LCK),
        .MAX_FAILS(MF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // reference model: run lengths for debounce, digit queue and absolute deadlines for the code FSM
    logic   m_s1[2], m_s2[2], m_stable[2], m_pend[2], mraw[2], mnew[2], e_click[2];
    int     m_run[2];
    logic   e_err = 1'b0, both, refresh, st;
    int     mode = M_IDLE, fails = 0, k;
    int     q[$];
    longint edge_n = 0, t_end = 0;

    initial begin
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_stable[b] = 0; m_pend[b] = 0; m_run[b] = 0; e_click[b] = 0;
        end
    end

    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_stable[b] = 0; m_pend[b] = 0; m_run[b] = 0; e_click[b] = 0;
            end
            mode = M_IDLE;
            q.delete();
            fails = 0;
            e_err = 0;
        end else begin
            mraw[0] = bus.on_btn_raw;
            mraw[1] = bus.off_btn_raw;
            for (int b = 0; b < 2; b++) begin
                mnew[b] = 0;
                if (m_s2[b] != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_stable[b] = !m_stable[b];
                        m_run[b] = 0;
                        mnew[b] = m_stable[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = mraw[b];
            end
            both = m_pend[0] && m_pend[1];
            for (int b = 0; b < 2; b++) begin
                e_click[b] = m_pend[b] && !both;
                m_pend[b] = mnew[b];
            end
            refresh = e_click[0] || e_click[1];
            e_err = 0;
            st = bus.key_strobe;
            k = int'(bus.key_digit);
            case (mode)
                M_IDLE: if (st && k <= 9) begin q = {k}; mode = M_ENTRY; end
                M_ENTRY: if (st) begin
                    if (k <= 9) q.push_back(k);
                    else if (k == 10) begin q.delete(); mode = M_IDLE; end
                    else if (k == 11) begin
                        if (q.size() == 4 && (q[0] * 4096 + q[1] * 256 + q[2] * 16 + q[3]) == int'(CODE_V)) begin
                            mode = M_UNLOCKED; fails = 0; t_end = edge_n + UNL;
                        end else begin
                            e_err = 1;
                            fails++;
                            if (fails == MF) begin mode = M_LOCKOUT; t_end = edge_n + LCK; end
                            else mode = M_IDLE;
                        end
                        q.delete();
                    end
                end
                M_UNLOCKED: begin
                    if (st && k == 10) mode = M_IDLE;
                    else if (refresh) t_end = edge_n + UNL;
                    else if (edge_n == t_end) mode = M_IDLE;
                end
                default: if (edge_n == t_end) begin mode = M_IDLE; fails = 0; end
            endcase
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("onClick", bus.onClick, e_click[0]);
        chk("offClick", bus.offClick, e_click[1]);
        chk("keypad", bus.keypad, mode == M_UNLOCKED);
        chk("locked_out", bus.locked_out, mode == M_LOCKOUT);
        chk("code_error", bus.code_error, e_err);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic keys(input logic [23:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            bus.key_strobe = 1'b1;
            bus.key_digit = seq[4*(n-1-i) +: 4];
            tick();
        end
        bus.key_strobe = 1'b0;
    endtask

    task automatic bad_entry();
        keys(24'h9B, 2);
        ticks(3);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_onClick"}, bus.onClick, 1'b0);
        chk({tag, "_offClick"}, bus.offClick, 1'b0);
        chk({tag, "_keypad"}, bus.keypad, 1'b0);
        chk({tag, "_locked_out"}, bus.locked_out, 1'b0);
        chk({tag, "_code_error"}, bus.code_error, 1'b0);
    endtask

    initial begin
        int first, c_on, c_off, c_key, c_lock, c_err, c, f, ptr;
        int pool[10] = '{0, 1, 2, 3, 4, 5, 10, 11, 12, 15};
        int code_seq[5] = '{1, 2, 3, 4, 11};
        logic [19:0] s = 20'h1234B;
        bus.on_btn_raw = 0; bus.off_btn_raw = 0; bus.key_strobe = 0; bus.key_digit = 0;
        @(posedge clk);
        ticks(3);
        all_zero("reset");
        reset = 0;
        ticks(5);

        bus.on_btn_raw = 1;
        first = 0; c_on = 0; c_off = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.onClick) begin c_on++; if (first == 0) first = i; end
            if (bus.offClick) c_off++;
        end
        chk_int("on_latency", first, 19);
        chk_int("on_pulses", c_on, 1);
        chk_int("off_pulses", c_off, 0);
        bus.on_btn_raw = 0;
        ticks(40);

        c_on = 0;
        for (int i = 0; i < 100; i++) begin
            if (i % 5 == 0) bus.on_btn_raw = ~bus.on_btn_raw;
            tick();
            if (bus.onClick) c_on++;
        end
        chk_int("glitch_pulses", c_on, 0);
        ticks(40);

        keys(24'h1234, 4);
        bus.key_strobe = 1; bus.key_digit = 4'hB;
        c_key = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            bus.key_strobe = 0;
            if (bus.keypad) c_key++;
        end
        chk_int("unlock_window", c_key, UNL);

        keys(24'h1234, 4);
        bus.key_strobe = 1; bus.key_digit = 4'hB;
        tick();
        bus.key_strobe = 0;
        ticks(480);
        bus.off_btn_raw = 1;
        c = -1; f = -1;
        for (int i = 0; i < 1700; i++) begin
            tick();
            if (i == 30) bus.off_btn_raw = 0;
            if (bus.offClick && c < 0) c = i;
            if (c >= 0 && f < 0 && !bus.keypad) f = i;
        end
        chk_int("refresh_window", f - c, UNL);

        keys(24'h1235, 4);
        bus.key_strobe = 1; bus.key_digit = 4'hB;
        c_err = 0; c_key = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); bus.key_strobe = 0;
            if (bus.code_error) c_err++;
            if (bus.keypad) c_key++;
        end
        chk_int("wrong_code_err", c_err, 1);
        chk_int("wrong_code_keypad", c_key, 0);

        keys(24'h12344, 5);
        bus.key_strobe = 1; bus.key_digit = 4'hB;
        c_err = 0; c_key = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); bus.key_strobe = 0;
            if (bus.code_error) c_err++;
            if (bus.keypad) c_key++;
        end
        chk_int("overflow_err", c_err, 1);
        chk_int("overflow_keypad", c_key, 0);

        reset = 1; tick(); reset = 0; tick();
        bad_entry();
        bad_entry();
        keys(24'h9, 1);
        bus.key_strobe = 1; bus.key_digit = 4'hB;
        c_lock = 0; c_key = 0;
        for (int i = 0; i < 4200; i++) begin
            tick();
            bus.key_strobe = (i >= 10 && i < 15);
            bus.key_digit = (i >= 10 && i < 15) ? s[4*(14-i) +: 4] : 4'h0;
            if (bus.locked_out) c_lock++;
            if (bus.keypad) c_key++;
        end
        chk_int("lockout_window", c_lock, LCK);
        chk_int("lockout_keypad", c_key, 0);
        keys(24'h1234, 4);
        bus.key_strobe = 1; bus.key_digit = 4'hB;
        tick(); bus.key_strobe = 0;
        chk("unlock_after_lockout", bus.keypad, 1'b1);
        ticks(3);
        bus.key_strobe = 1; bus.key_digit = 4'hA;
        tick(); bus.key_strobe = 0;
        chk("clear_relock", bus.keypad, 1'b0);
        ticks(3);

        bad_entry(); bad_entry(); bad_entry();
        ticks(100);
        chk("lockout_before_reset", bus.locked_out, 1'b1);
        reset = 1; tick();
        all_zero("mid_lockout_reset");
        reset = 0; ticks(5);

        bus.on_btn_raw = 1; bus.off_btn_raw = 1;
        c_on = 0; c_off = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.onClick) c_on++;
            if (bus.offClick) c_off++;
        end
        chk_int("both_on_pulses", c_on, 0);
        chk_int("both_off_pulses", c_off, 0);
        bus.on_btn_raw = 0; bus.off_btn_raw = 0;
        ticks(40);

        ptr = 0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            reset = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 19) == 0) bus.on_btn_raw = ~bus.on_btn_raw;
            if ($urandom_range(0, 19) == 0) bus.off_btn_raw = ~bus.off_btn_raw;
            if (ptr == 0 && $urandom_range(0, 99) == 0) ptr = 1;
            if (ptr > 0) begin
                bus.key_strobe = 1;
                bus.key_digit = 4'(code_seq[ptr-1]);
                ptr = (ptr == 5) ? 0 : ptr + 1;
            end else begin
                bus.key_strobe = ($urandom_range(0, 3) == 0);
                bus.key_digit = 4'(pool[$urandom_range(0, 9)]);
            end
        end
        reset = 0; bus.key_strobe = 0;
        ticks(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
